// File: rtl/filter_chan_seq_if.sv
// FIR sink/source handshake and processed-result stream for filter_chan_seq.
// The sequencer drives the master modport; the FIR side and result consumer use the slave modport.
interface filter_chan_seq_if #(
    parameter int IN_W  = 12,
    parameter int OUT_W = 24,
    parameter int CH_W  = 3
);
    logic [IN_W:0]    fir_sink_data;
    logic             fir_sink_valid;
    logic [OUT_W-1:0] fir_source_data;
    logic             fir_source_valid;
    logic [OUT_W-1:0] out_data;
    logic [CH_W-1:0]  out_ch;
    logic             out_valid;

    modport master (
        output fir_sink_data, fir_sink_valid, out_data, out_ch, out_valid,
        input  fir_source_data, fir_source_valid
    );

    modport slave (
        input  fir_sink_data, fir_sink_valid, out_data, out_ch, out_valid,
        output fir_source_data, fir_source_valid
    );
endinterface

// File: rtl/filter_chan_seq.sv
// Per-frame channel sequencer: issues enabled channels to a shared FIR, tags results
// in issue order, and post-processes each result according to the frame's mode.
module filter_chan_seq #(
    parameter int NCH   = 4,
    parameter int IN_W  = 12,
    parameter int OUT_W = 24,
    parameter int CH_W  = 3
) (
    input  logic                clk1,
    input  logic                reset_n,
    input  logic                sample_strobe,
    input  logic [NCH*IN_W-1:0] ch_data,
    input  logic [NCH-1:0]      ch_enable,
    input  logic [1:0]          mode,
    filter_chan_seq_if.master   bus,
    output logic                frame_done,
    output logic                overrun,
    output logic                tag_err
);

    localparam int CNT_W = $clog2(NCH + 1);
    localparam int PTR_W = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [OUT_W-1:0] MAX_POS = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] MIN_NEG = {1'b1, {(OUT_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t              state;
    logic                sync_r0, sync_r1, sync_r2;
    logic                frame_start;
    logic [NCH*IN_W-1:0] data_r;
    logic [NCH-1:0]      pend_r;
    logic [1:0]          mode_r;

    logic [CH_W-1:0]     tag_mem [NCH];
    logic [PTR_W-1:0]    wr_ptr, rd_ptr;
    logic [CNT_W-1:0]    count;

    logic [NCH-1:0]      issue_onehot, pend_rest;
    logic [CH_W-1:0]     issue_idx;
    logic [IN_W-1:0]     issue_sample;
    logic                do_issue, do_pop;

    // sample_strobe comes from another clock domain
    always_ff @(posedge clk1 or negedge reset_n) begin
        if (!reset_n) begin
            sync_r0 <= 1'b0;
            sync_r1 <= 1'b0;
            sync_r2 <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every flop sample pre-edge values, so the chain shifts one stage per clock.
            sync_r0 <= sample_strobe;
            sync_r1 <= sync_r0;
            sync_r2 <= sync_r1;
        end
    end

    assign frame_start = sync_r1 & ~sync_r2;

    // Lowest pending channel wins; disabled channels never occupy a cycle.
    always_comb begin
        // NOTE: defaults assigned first so no path leaves a variable unassigned, which would infer a latch.
        issue_idx    = '0;
        issue_sample = '0;
        issue_onehot = pend_r & (~pend_r + 1'b1);
        pend_rest    = pend_r & ~issue_onehot;
        for (int i = 0; i < NCH; i++) begin
            if (issue_onehot[i]) begin
                issue_idx    = CH_W'(i);
                issue_sample = data_r[i*IN_W +: IN_W];
            end
        end
    end

    assign do_issue = (state == ISSUE);
    assign do_pop   = bus.fir_source_valid && (count != '0);

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (int'(p) == NCH - 1) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [OUT_W-1:0] post_proc(input logic [OUT_W-1:0] x, input logic [1:0] m);
        logic [OUT_W-1:0] mag;
        logic [OUT_W:0]   rnd;
        if (!x[OUT_W-1])      mag = x;
        else if (x == MIN_NEG) mag = MAX_POS;
        else                  mag = ~x + 1'b1;
        rnd = ({1'b0, mag} + (OUT_W+1)'(8)) >> 4;
        case (m)
            2'd0:    post_proc = x;
            2'd1:    post_proc = mag;
            2'd2:    post_proc = x[OUT_W-1] ? '0 : x;
            default: post_proc = (rnd > {1'b0, MAX_POS}) ? MAX_POS : rnd[OUT_W-1:0];
        endcase
    endfunction

    always_ff @(posedge clk1 or negedge reset_n) begin
        if (!reset_n) begin
            state              <= IDLE;
            data_r             <= '0;
            pend_r             <= '0;
            mode_r             <= '0;
            bus.fir_sink_data  <= '0;
            bus.fir_sink_valid <= 1'b0;
            frame_done         <= 1'b0;
            overrun            <= 1'b0;
        end else begin
            bus.fir_sink_valid <= 1'b0;
            frame_done         <= 1'b0;
            if (frame_start && state != IDLE) overrun <= 1'b1;
            case (state)
                IDLE: if (frame_start) begin
                    data_r <= ch_data;
                    pend_r <= ch_enable;
                    mode_r <= mode;
                    if (ch_enable == '0) begin
                        state      <= DONE;
                        frame_done <= 1'b1;
                    end else begin
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    bus.fir_sink_data  <= {1'b0, issue_sample};
                    bus.fir_sink_valid <= 1'b1;
                    pend_r             <= pend_rest;
                    if (pend_rest == '0) state <= DRAIN;
                end
                DRAIN: if (count == '0) begin
                    state      <= DONE;
                    frame_done <= 1'b1;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Tags return in issue order, so a small FIFO pairs each result with its channel.
    always_ff @(posedge clk1 or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: the tag store is only NCH entries, so it is cleared with the rest; larger memories are normally left unreset.
            for (int i = 0; i < NCH; i++) tag_mem[i] <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            bus.out_data  <= '0;
            bus.out_ch    <= '0;
            bus.out_valid <= 1'b0;
            tag_err       <= 1'b0;
        end else begin
            bus.out_valid <= 1'b0;
            if (do_issue) begin
                tag_mem[wr_ptr] <= issue_idx;
                wr_ptr          <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                bus.out_data  <= post_proc(bus.fir_source_data, mode_r);
                bus.out_ch    <= tag_mem[rd_ptr];
                bus.out_valid <= 1'b1;
                rd_ptr        <= ptr_inc(rd_ptr);
            end else if (bus.fir_source_valid) begin
                tag_err <= 1'b1;
            end
            case ({do_issue, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: doc/filter_chan_seq.md
FILTER_CHAN_SEQ -- requirements
Module: filter_chan_seq

Interface
REQ-001 Parameter NCH, default 4: number of channels, legal 1..8.
REQ-002 Parameter IN_W, default 12: channel sample width, unsigned.
REQ-003 Parameter OUT_W, default 24: FIR result width, two's complement.
REQ-004 Parameter CH_W, default 3: channel tag width, ≥ clog2(NCH), minimum 1.
REQ-005 clk1  in  1  single 50 MHz clock.
REQ-006 reset_n  in  1  reset, asynchronous and active-low.
REQ-007 sample_strobe  in  1  frame strobe from decimator, asynchronous to clk1.
REQ-008 ch_data  in  NCH*IN_W  channel samples, channel k at bits [k*IN_W +: IN_W].
REQ-009 ch_enable  in  NCH  per-channel enable; sampled at frame start.
REQ-010 mode  in  2  post-processing mode; sampled at frame start.
REQ-011 fir_sink_data  out  IN_W+1  {1'b0, sample} to shared FIR.
REQ-012 fir_sink_valid  out  1  one-cycle sample-valid pulse to FIR.
REQ-013 fir_source_data  in  OUT_W  FIR result.
REQ-014 fir_source_valid  in  1  FIR result valid; results return in issue order, arbitrary latency.
REQ-015 out_data  out  OUT_W  processed result, held between valids.
REQ-016 out_ch  out  CH_W  channel of out_data.
REQ-017 out_valid  out  1  one-cycle pulse per result.
REQ-018 frame_done  out  1  one-cycle pulse when all results of a frame are delivered.
REQ-019 overrun  out  1  sticky: strobe edge arrived while frame busy.
REQ-020 tag_err  out  1  sticky: FIR result arrived with no outstanding tag.

Function
REQ-021 sample_strobe SHALL pass through a 3-flop synchroniser; frame start = rising edge of stages 2/3 (sync_r1 & ~sync_r2).
REQ-022 FSM states IDLE, ISSUE, DRAIN, DONE; reset state IDLE.
REQ-023 IDLE + edge: latch ch_data, ch_enable, mode into frame registers; go ISSUE next cycle.
REQ-024 ISSUE: one enabled channel per cycle, ascending index, disabled channels skipped with zero cycles spent; each issue drives fir_sink_valid=1 with latched sample and pushes the channel index into a tag FIFO of depth NCH.
REQ-025 After the last enabled channel is issued → DRAIN; if no channel is enabled, IDLE → DONE directly, no FIR traffic.
REQ-026 DRAIN: stay until outstanding count = 0, then → DONE; DONE asserts frame_done for one cycle, then → IDLE.
REQ-027 Outstanding count: +1 per issue, -1 per accepted result, both in the same cycle → unchanged.
REQ-028 Edge while not IDLE: dropped, overrun set; the current frame is unaffected.
REQ-029 fir_source_valid: pop tag; register processed result → out_data/out_ch, out_valid=1 exactly one cycle later (latency 1).
REQ-030 fir_source_valid with empty tag FIFO: result discarded, no out_valid, tag_err set.
REQ-031 Mode 0: out_data = fir_source_data unchanged.
REQ-032 Mode 1: magnitude; negative x → two's complement negation (~x + 1); x = -2^(OUT_W-1) → 2^(OUT_W-1)-1.
REQ-033 Mode 2: negative clamped to 0, non-negative unchanged.
REQ-034 Mode 3: magnitude as mode 1, then arithmetic right shift by 4 with round-half-up, never exceeding 2^(OUT_W-1)-1.
REQ-035 Mode change takes effect only at the next frame start.

Reset
REQ-036 reset_n low: FSM IDLE, synchroniser flops, tag FIFO, outstanding count and frame registers cleared; all outputs 0, including overrun and tag_err.
REQ-037 Reset asserted mid-frame: frame aborted, no frame_done; results arriving after release with empty FIFO set tag_err.
REQ-038 overrun and tag_err clear only on reset.

Verification
REQ-039 NCH=4, all enabled, mode 0, FIR model latency 7: one strobe → 4 sink pulses on consecutive cycles, results ch 0..3 in order, out_valid 1 cycle after each source valid, frame_done one cycle after last drain.
REQ-040 ch_enable=4'b1010, mode 1, FIR returns -5 and 0x800000: out (ch1, 5), (ch3, 0x7FFFFF); exactly 2 sink pulses.
REQ-041 ch_enable=0: strobe → frame_done pulse, zero sink pulses, no out_valid.
REQ-042 Second strobe during DRAIN: overrun=1, frame completes normally, next strobe after IDLE starts a normal frame.
REQ-043 Mode 3, result 0x000018 → 0x000002; mode 2, result -1 → 0; same-cycle issue and result keep count correct.
REQ-044 Source valid in IDLE → tag_err=1, no out_valid; reset_n pulse mid-ISSUE → all outputs 0, FSM IDLE.
